// File: rtl/timer_cmd_rx.sv
// Purpose: UART (8N1, or 8E1 when TIMER_CMD_PARITY_EN is defined) receiver that decodes ASCII commands into timer control pulses.
// Latency: pulses/cmd_valid/sel/rx_byte update on the edge after the stop-bit mid-sample (2 sync cycles + 9.5 bit times after the start edge).
// Backpressure: none; every output event is a single-cycle pulse that the timer consumes immediately.
module timer_cmd_rx #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [1:0] SEL_RESET    = 2'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       inc,
    output logic       dec,
    output logic       state,
    output logic       start,
    output logic [1:0] sel,
    output logic       cmd_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef TIMER_CMD_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DISPATCH, S_BREAK
    } fsm_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_DISPATCH, S_BREAK
    } fsm_t;
`endif

    fsm_t          fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          rx_meta, rx_s;

    logic          inc_d, dec_d, state_d, start_d, cmd_valid_d, frame_err_d;
    logic [1:0]    sel_d;
    logic [7:0]    rx_byte_d;

`ifdef TIMER_CMD_PARITY_EN
    logic          par_q, par_d;
    logic          par_bad;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_bad = ^{shreg_q, par_q};
`endif

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state, bit timing and data shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q   <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
`ifdef TIMER_CMD_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
`ifdef TIMER_CMD_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Registered outputs: loaded on the edge that enters DISPATCH (or BREAK for a bad stop bit).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inc       <= 1'b0;
            dec       <= 1'b0;
            state     <= 1'b0;
            start     <= 1'b0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            sel       <= SEL_RESET;
            rx_byte   <= 8'h00;
        end else begin
            inc       <= inc_d;
            dec       <= dec_d;
            state     <= state_d;
            start     <= start_d;
            cmd_valid <= cmd_valid_d;
            frame_err <= frame_err_d;
            sel       <= sel_d;
            rx_byte   <= rx_byte_d;
        end
    end

    // Next-state, bit sampling and command decode.
    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
`ifdef TIMER_CMD_PARITY_EN
        par_d       = par_q;
`endif
        inc_d       = 1'b0;
        dec_d       = 1'b0;
        state_d     = 1'b0;
        start_d     = 1'b0;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        sel_d       = sel;
        rx_byte_d   = rx_byte;

        case (fsm_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) fsm_d = S_START;
            end

            // Re-check the line at mid start bit to reject short glitches silently.
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    fsm_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // LSB first: each mid-bit sample enters at the top and shifts down.
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) begin
`ifdef TIMER_CMD_PARITY_EN
                        fsm_d = S_PARITY;
`else
                        fsm_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef TIMER_CMD_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    par_d = rx_s;
                    fsm_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif

            // A bad stop bit wins over everything else and parks in BREAK.
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        fsm_d       = S_BREAK;
                    end else begin
                        fsm_d = S_DISPATCH;
`ifdef TIMER_CMD_PARITY_EN
                        if (par_bad) begin
                            frame_err_d = 1'b1;
                        end else
`endif
                        begin
                            rx_byte_d = shreg_q;
                            case (shreg_q)
                                8'h2B: begin inc_d   = 1'b1; cmd_valid_d = 1'b1; end
                                8'h2D: begin dec_d   = 1'b1; cmd_valid_d = 1'b1; end
                                8'h4D: begin state_d = 1'b1; cmd_valid_d = 1'b1; end
                                8'h53: begin start_d = 1'b1; cmd_valid_d = 1'b1; end
                                8'h30, 8'h31, 8'h32, 8'h33: begin
                                    sel_d       = shreg_q[1:0];
                                    cmd_valid_d = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Outputs are already presented this cycle; return so a new start bit is seen at once.
            S_DISPATCH: fsm_d = S_IDLE;

            // Held-low line: wait for idle so only one frame_err is reported.
            S_BREAK: begin
                if (rx_s) fsm_d = S_IDLE;
            end

            default: fsm_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_timer_cmd_rx.sv
// Purpose: randomized scoreboard bench for timer_cmd_rx against an ASCII-level command model.
// Latency: expected events carry the cycle they should appear (start edge + 2 + (bits - 0.5) bit times, +/-2).
// Backpressure: none; the monitor consumes one expected event per observed output event.
module tb_timer_cmd_rx;

    localparam int         CPB       = 16;
    localparam logic [1:0] SEL_RST   = 2'd2;
`ifdef TIMER_CMD_PARITY_EN
    localparam int         NBITS     = 11;
`else
    localparam int         NBITS     = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       inc, dec, state, start, cmd_valid, frame_err;
    logic [1:0] sel;
    logic [7:0] rx_byte;

    timer_cmd_rx #(.CLKS_PER_BIT(CPB), .SEL_RESET(SEL_RST)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .inc       (inc),
        .dec       (dec),
        .state     (state),
        .start     (start),
        .sel       (sel),
        .cmd_valid (cmd_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse vector order: inc, dec, state, start, cmd_valid, frame_err.
    typedef struct {
        logic [5:0] pulses;
        logic [1:0] sel;
        logic [7:0] byte_v;
        int         cyc;
    } exp_t;

    exp_t       expq[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] mdl_sel  = SEL_RST;
    logic [7:0] mdl_byte = 8'h00;
    logic [7:0] prev_byte = 8'h00;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: what a host typing this byte should cause at the timer.
    task automatic model_byte(input logic [7:0] b, input int t0);
        exp_t       e;
        logic [7:0] old;
        old      = mdl_byte;
        e.pulses = 6'b000000;
        case (b)
            "+":                     e.pulses = 6'b100010;
            "-":                     e.pulses = 6'b010010;
            "M":                     e.pulses = 6'b001010;
            "S":                     e.pulses = 6'b000110;
            "0", "1", "2", "3": begin
                e.pulses = 6'b000010;
                mdl_sel  = b[1:0];
            end
            default:                 e.pulses = 6'b000000;
        endcase
        mdl_byte = b;
        e.sel    = mdl_sel;
        e.byte_v = b;
        e.cyc    = t0 + 2 + CPB * NBITS - CPB / 2;
        if (e.pulses != 6'b0 || b != old) expq.push_back(e);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_bits);
        @(posedge clk);
        #1;
        model_byte(b, cyc);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef TIMER_CMD_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(1'b1);
        for (int i = 0; i < gap_bits; i++) drive_bit(1'b1);
    endtask

    task automatic send_break(input int bits_low);
        exp_t e;
        @(posedge clk);
        #1;
        e.pulses = 6'b000001;
        e.sel    = mdl_sel;
        e.byte_v = mdl_byte;
        e.cyc    = cyc + 2 + CPB * NBITS - CPB / 2;
        expq.push_back(e);
        rx = 1'b0;
        repeat (bits_low * CPB) @(posedge clk);
        #1;
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    // Monitor: any pulse or rx_byte change is an event that must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (!reset) begin
            prev_byte = rx_byte;
        end else if ({inc, dec, state, start, cmd_valid, frame_err} != 6'b0 || rx_byte != prev_byte) begin
            prev_byte = rx_byte;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event pulses=%b rx_byte=0x%0h at cycle %0d",
                         {inc, dec, state, start, cmd_valid, frame_err}, rx_byte, cyc);
            end else begin
                e = expq.pop_front();
                chk("pulses", int'({inc, dec, state, start, cmd_valid, frame_err}), int'(e.pulses));
                chk("sel", int'(sel), int'(e.sel));
                chk("rx_byte", int'(rx_byte), int'(e.byte_v));
                lat = cyc - e.cyc;
                checks++;
                if (lat < -2 || lat > 2) begin
                    errors++;
                    $display("FAIL latency actual_cycle=%0d expected_cycle=%0d", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] cmds [8];
        logic [7:0] b;
        logic [7:0] plus_v;
        int         waited;
        cmds[0] = "+"; cmds[1] = "-"; cmds[2] = "M"; cmds[3] = "S";
        cmds[4] = "0"; cmds[5] = "1"; cmds[6] = "2"; cmds[7] = "3";

        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pulses", int'({inc, dec, state, start, cmd_valid, frame_err}), 0);
        chk("rst_rx_byte", int'(rx_byte), 0);
        chk("rst_sel", int'(sel), int'(SEL_RST));
        #1 reset = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("idle_sel", int'(sel), int'(SEL_RST));

        // Directed cases: inc, sel then start back-to-back, unknown byte, break, dec.
        send_byte(8'h2B, 1);
        send_byte("1", 0);
        send_byte("S", 1);
        send_byte("A", 1);
        send_break(30);
        send_byte(8'h2D, 1);

        // Short low glitch must be rejected without error.
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);

        // Reset in the middle of the data bits of a '+' frame.
        plus_v = 8'h2B;
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(plus_v[i]);
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        mdl_sel  = SEL_RST;
        mdl_byte = 8'h00;
        @(negedge clk);
        chk("midreset_sel", int'(sel), int'(SEL_RST));
        repeat (2 * CPB) @(posedge clk);
        send_byte("M", 1);

        // Randomized mix of commands and arbitrary bytes with random idle gaps.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 0) b = cmds[$urandom_range(0, 7)];
            else                           b = 8'($urandom);
            send_byte(b, $urandom_range(0, 2));
        end

        waited = 0;
        while (expq.size() != 0 && waited < 400) begin
            @(posedge clk);
            waited++;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        chk("final_sel", int'(sel), int'(mdl_sel));
        chk("final_rx_byte", int'(rx_byte), int'(mdl_byte));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
